line_refill_engine: RTL and testbench

- Miss-handling stage directly downstream of the data cache, between the cache and the backing main memory.
- On a cache miss, the cache hands over the missing line address and the victim line.
- The engine writes the victim back word-by-word if it is dirty, then fetches the new line word-by-word over a valid/ready memory port.
- It returns the assembled line to the cache with a one-cycle fill pulse.

---
 rtl/line_refill_engine_pkg.sv | 16 +
 rtl/line_refill_engine.sv | 134 +++++++++++++
 tb/tb_line_refill_engine.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_refill_engine_pkg.sv
// Shared types for the cache miss/refill path: FSM states and the line bus.
package line_refill_engine_pkg;

    localparam int LINE_WORDS = 4;

    typedef logic [32*LINE_WORDS-1:0] LINE_BUS;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD_REQ,
        RD_WAIT,
        DONE
    } refill_state_e;

endpackage

// File: rtl/line_refill_engine.sv
// Cache miss handler: optional dirty-victim writeback, then word-by-word line fetch,
// returned to the cache with a one-cycle fill pulse. One read outstanding at a time.
module line_refill_engine
    import line_refill_engine_pkg::*;
#(
    parameter int LINE_WORDS = line_refill_engine_pkg::LINE_WORDS,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [ADDR_WIDTH-1:0]    miss_addr,
    input  logic                     victim_dirty,
    input  logic [ADDR_WIDTH-1:0]    victim_addr,
    input  logic [32*LINE_WORDS-1:0] victim_line,
    output logic                     fill_valid,
    output logic [ADDR_WIDTH-1:0]    fill_addr,
    output logic [32*LINE_WORDS-1:0] fill_line,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr,
    output logic [31:0]              mem_req_wdata,
    input  logic                     mem_rsp_valid,
    input  logic [31:0]              mem_rsp_rdata,
    output logic                     busy
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFS_W = IDX_W + 2;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFS_W) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    refill_state_e              state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]      miss_base_q, miss_base_d;
    logic [ADDR_WIDTH-1:0]      vic_base_q, vic_base_d;
    logic [32*LINE_WORDS-1:0]   vic_line_q, vic_line_d;
    logic [32*LINE_WORDS-1:0]   line_q, line_d;
    logic [ADDR_WIDTH-1:0]      word_ofs;

    assign word_ofs = {{(ADDR_WIDTH-OFS_W){1'b0}}, idx_q, 2'b00};

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        miss_base_d   = miss_base_q;
        vic_base_d    = vic_base_q;
        vic_line_d    = vic_line_q;
        line_d        = line_q;
        miss_ready    = 1'b0;
        fill_valid    = 1'b0;
        fill_addr     = '0;
        fill_line     = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        busy          = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so the cache never sees a phantom accept.
                miss_ready = !rst;
                if (miss_valid && !rst) begin
                    miss_base_d = miss_addr & LINE_MASK;
                    vic_base_d  = victim_addr & LINE_MASK;
                    vic_line_d  = victim_line;
                    idx_d       = '0;
                    state_d     = victim_dirty ? WB : RD_REQ;
                end
            end
            WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = vic_base_q | word_ofs;
                mem_req_wdata = vic_line_q[32*idx_q +: 32];
                if (mem_req_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = RD_REQ;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = miss_base_q | word_ofs;
                if (mem_req_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rsp_valid) begin
                    line_d[32*idx_q +: 32] = mem_rsp_rdata;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                fill_valid = 1'b1;
                fill_addr  = miss_base_q;
                fill_line  = line_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            miss_base_q <= '0;
            vic_base_q  <= '0;
            vic_line_q  <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            miss_base_q <= miss_base_d;
            vic_base_q  <= vic_base_d;
            vic_line_q  <= vic_line_d;
            line_q      <= line_d;
        end
    end

endmodule

// File: tb/tb_line_refill_engine.sv
// Randomized bench for line_refill_engine: memory responder, transaction-level model, per-cycle compare.
module tb_line_refill_engine;

    localparam int LW = 4;
    localparam int AW = 32;
    localparam logic [31:0] LMASK = ~32'(4*LW - 1);

    logic            clk;
    logic            rst;
    logic            miss_valid;
    logic            miss_ready;
    logic [AW-1:0]   miss_addr;
    logic            victim_dirty;
    logic [AW-1:0]   victim_addr;
    logic [32*LW-1:0] victim_line;
    logic            fill_valid;
    logic [AW-1:0]   fill_addr;
    logic [32*LW-1:0] fill_line;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_we;
    logic [AW-1:0]   mem_req_addr;
    logic [31:0]     mem_req_wdata;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_rdata;
    logic            busy;

    line_refill_engine #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_line(victim_line),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Backing memory contents: a pinned window at 0x1230 and a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000123) return 32'hA0 + {30'd0, a[3:2]};
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    // ---------------- model + compare (negedge) ----------------
    req_t         exp_q[$];
    logic [127:0] exp_line;
    logic [31:0]  exp_fill_addr;
    bit           outstanding = 0, read_out = 0, fill_next = 0, exp_fill = 0;
    int           rsp_cnt = 0;
    bit           prev_rst = 1, prev_v = 0, prev_r = 0;
    req_t         prev_req, cur_req;
    bit           hs_rd = 0, hs_any = 0;
    logic [31:0]  hs_rd_addr;
    int           accept_cnt = 0, fill_cnt = 0, accept_cyc = 0, fill_cyc = -100, last_lat = 0;
    logic [127:0] last_fill_line;
    logic [31:0]  last_fill_addr, first_wr_addr, first_wr_data;
    bit           first_wr_seen = 0;
    logic [31:0]  mb, vb;

    always @(negedge clk) begin
        hs_rd  = 0;
        hs_any = 0;
        cur_req = '{addr: mem_req_addr, we: mem_req_we, wdata: mem_req_wdata};
        if (rst) begin
            chk("miss_ready_in_reset", miss_ready, 1'b0);
            exp_q.delete();
            outstanding = 0; read_out = 0; fill_next = 0; rsp_cnt = 0;
            prev_rst = 1; prev_v = 0; prev_r = 0;
        end else begin
            if (prev_rst) begin
                chk("rst_outputs_zero",
                    {fill_valid, mem_req_valid, mem_req_we, busy, mem_req_addr, mem_req_wdata, fill_addr},
                    '0);
                chk("rst_fill_line", fill_line, '0);
                chk("rst_miss_ready", miss_ready, 1'b1);
            end
            exp_fill  = fill_next;
            fill_next = 0;
            chk("miss_ready", miss_ready, !outstanding);
            chk("busy", busy, outstanding);
            chk("fill_valid", fill_valid, exp_fill);
            if (fill_valid && exp_fill) begin
                chk("fill_addr", fill_addr, exp_fill_addr);
                chk("fill_line", fill_line, exp_line);
                fill_cnt++;
                fill_cyc = cyc;
                last_lat = cyc - accept_cyc;
                last_fill_line = fill_line;
                last_fill_addr = fill_addr;
            end
            if (exp_fill) outstanding = 0;

            if (prev_v && !prev_r) begin
                chk("req_hold_valid", mem_req_valid, 1'b1);
                chk("req_hold_fields", cur_req, prev_req);
            end

            if (mem_rsp_valid && read_out) begin
                read_out = 0;
                rsp_cnt++;
                if (rsp_cnt == LW) fill_next = 1;
            end

            if (mem_req_valid) begin
                hs_any = mem_req_ready;
                hs_rd  = mem_req_ready && !mem_req_we;
                hs_rd_addr = mem_req_addr;
                chk("req_expected", (exp_q.size() > 0) && !read_out, 1'b1);
                if (exp_q.size() > 0 && !read_out) begin
                    chk("req_addr", mem_req_addr, exp_q[0].addr);
                    chk("req_we", mem_req_we, exp_q[0].we);
                    if (exp_q[0].we) chk("req_wdata", mem_req_wdata, exp_q[0].wdata);
                    if (mem_req_ready) begin
                        if (exp_q[0].we && !first_wr_seen) begin
                            first_wr_seen = 1;
                            first_wr_addr = mem_req_addr;
                            first_wr_data = mem_req_wdata;
                        end
                        if (!exp_q[0].we) read_out = 1;
                        void'(exp_q.pop_front());
                    end
                end
            end

            if (miss_valid && miss_ready && !outstanding) begin
                mb = miss_addr & LMASK;
                vb = victim_addr & LMASK;
                if (victim_dirty)
                    for (int i = 0; i < LW; i++)
                        exp_q.push_back('{addr: vb + 32'(4*i), we: 1'b1, wdata: victim_line[32*i +: 32]});
                for (int i = 0; i < LW; i++) begin
                    exp_q.push_back('{addr: mb + 32'(4*i), we: 1'b0, wdata: 32'd0});
                    exp_line[32*i +: 32] = mem_word(mb + 32'(4*i));
                end
                exp_fill_addr = mb;
                outstanding = 1;
                rsp_cnt = 0;
                accept_cnt++;
                accept_cyc = cyc;
            end
            prev_v = mem_req_valid;
            prev_r = mem_req_ready;
            prev_req = cur_req;
            prev_rst = 0;
        end
    end

    // ---------------- memory responder ----------------
    int          stall_cfg = 0, delay_cfg = 1, stall_left = 0, rsp_wait = 0;
    bit          stray_en = 0, rand_mode = 0;
    logic [31:0] pend_addr;

    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (hs_rd) begin
                rsp_wait  = rand_mode ? int'($urandom_range(1, 4)) : delay_cfg;
                pend_addr = hs_rd_addr;
            end
            if (hs_any) stall_left = rand_mode ? int'($urandom_range(0, 3)) : stall_cfg;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = mem_word(pend_addr);
                end
            end else if (stray_en && $urandom_range(0, 2) == 0) begin
                mem_rsp_valid = 1'b1;
            end
            if (mem_req_valid) begin
                if (stall_left > 0) begin
                    mem_req_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_req_ready = 1'b1;
                end
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- sequencer ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic set_mem(input int stall, input int dly, input bit stray, input bit rnd);
        stall_cfg = stall; delay_cfg = dly; stray_en = stray; rand_mode = rnd;
        stall_left = stall;
    endtask

    task automatic run_miss(input logic [31:0] ma, input bit dirty, input logic [31:0] va,
                            input logic [127:0] vl, input bit wait_fill);
        int a0, f0, t;
        a0 = accept_cnt; f0 = fill_cnt;
        miss_addr = ma; victim_dirty = dirty; victim_addr = va; victim_line = vl;
        miss_valid = 1'b1;
        t = 0;
        while (accept_cnt == a0 && t < 300) begin tick(); t++; end
        if (accept_cnt == a0) chk("accept_timeout", 1'b0, 1'b1);
        miss_valid = 1'b0;
        // scramble miss-side inputs: they must not be resampled after accept
        miss_addr = $urandom; victim_addr = $urandom; victim_dirty = 1'($urandom);
        victim_line = {$urandom, $urandom, $urandom, $urandom};
        if (wait_fill) begin
            t = 0;
            while (fill_cnt == f0 && t < 2000) begin tick(); t++; end
            if (fill_cnt == f0) chk("fill_timeout", 1'b0, 1'b1);
        end
    endtask

    int t0, f0;

    initial begin
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
        victim_addr = '0; victim_line = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // clean miss, zero-wait
        set_mem(0, 1, 0, 0);
        run_miss(32'h0000_1234, 1'b0, 32'h0, 128'h0, 1'b1);
        chk("clean_fill_addr", last_fill_addr, 32'h0000_1230);
        chk("clean_fill_line", last_fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("clean_latency", 32'(last_lat), 32'd9);
        tick();

        // dirty miss, zero-wait
        first_wr_seen = 0;
        run_miss(32'h0000_4000, 1'b1, 32'h0000_2008, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
        chk("dirty_first_wr_addr", first_wr_addr, 32'h0000_2000);
        chk("dirty_first_wr_data", first_wr_data, 32'h11);
        chk("dirty_fill_addr", last_fill_addr, 32'h0000_4000);
        chk("dirty_latency", 32'(last_lat), 32'd13);
        tick();

        // backpressure: 3 stall cycles per request
        set_mem(3, 1, 0, 0);
        run_miss(32'h0000_1238, 1'b1, 32'h0000_7FFC, {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001}, 1'b1);
        chk("stall_fill_line", last_fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("stall_latency", 32'(last_lat), 32'd37);
        tick();

        // slow responses plus strays in IDLE/WB
        set_mem(0, 5, 1, 0);
        repeat (6) tick();
        run_miss(32'h0000_8010, 1'b1, 32'h0000_9000, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        chk("slow_latency", 32'(last_lat), 32'd29);
        set_mem(0, 1, 0, 0);
        repeat (3) tick();

        // reset after the second read response
        f0 = fill_cnt;
        run_miss(32'h0000_1230, 1'b0, 32'h0, 128'h0, 1'b0);
        t0 = 0;
        while (rsp_cnt < 2 && t0 < 200) begin tick(); t0++; end
        chk("midfill_progress", 32'(rsp_cnt), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stray_en = 1;
        repeat (10) tick();
        stray_en = 0;
        chk("midfill_no_fill", 32'(fill_cnt), 32'(f0));
        run_miss(32'h0000_123C, 1'b0, 32'h0, 128'h0, 1'b1);
        chk("after_rst_fill_addr", last_fill_addr, 32'h0000_1230);
        chk("after_rst_latency", 32'(last_lat), 32'd9);
        tick();

        // back-to-back with miss_valid held
        t0 = accept_cnt;
        miss_addr = 32'h0000_5550; victim_dirty = 1'b0; victim_addr = 32'h0; victim_line = '0;
        miss_valid = 1'b1;
        f0 = 0;
        while (accept_cnt < t0 + 2 && f0 < 500) begin tick(); f0++; end
        miss_valid = 1'b0;
        chk("b2b_two_accepts", 32'(accept_cnt - t0), 32'd2);
        chk("b2b_gap", 32'(accept_cyc - fill_cyc), 32'd1);
        f0 = fill_cnt;
        t0 = 0;
        while (fill_cnt == f0 && t0 < 500) begin tick(); t0++; end
        chk("b2b_second_fill", 32'(fill_cnt - f0), 32'd1);
        tick();

        // randomized traffic
        set_mem(0, 1, 0, 1);
        for (int k = 0; k < 30; k++) begin
            stray_en = 1'($urandom_range(0, 1));
            run_miss($urandom, 1'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        stray_en = 0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
